// File: rtl/muldiv_if.sv
// muldiv_if: start/busy/done handshake between the execute stage and the multiply/divide unit
interface muldiv_if #(parameter int XLEN = 32);
  logic            start;
  logic            flush;
  logic [4:0]      operation;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  modport master(output start, flush, operation, operand_a, operand_b, input busy, done, result);
  modport slave(input start, flush, operation, operand_a, operand_b, output busy, done, result);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, shared shift-add / restoring-divide datapath
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input logic     clk,
  input logic     rst,
  muldiv_if.slave io
);
  localparam int CW = $clog2(XLEN);
  localparam logic [4:0] MUL = 5'd10, MULH = 5'd11, MULHSU = 5'd12, MULHU = 5'd13,
                         DIV = 5'd14, DIVU = 5'd15, REM = 5'd16, REMU = 5'd17;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;
  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic [4:0]        op_q;
  logic [XLEN-1:0]   mb_q, result_q;
  logic [2*XLEN-1:0] acc_q, acc_d, prod;
  logic              neg_q, an_q, dz_q, busy_q, done_q;
  logic              is_m, sa, sb, an, bn, is_div;
  logic [XLEN:0]     add_sum, trial;
  logic [XLEN-1:0]   ma, mb, quo, rem_v, res_d;
  always_comb begin
    is_m    = io.operation >= MUL && io.operation <= REMU;
    sa      = io.operation == MULH || io.operation == MULHSU || io.operation == DIV || io.operation == REM;
    sb      = io.operation == MULH || io.operation == DIV || io.operation == REM;
    an      = sa & io.operand_a[XLEN-1];
    bn      = sb & io.operand_b[XLEN-1];
    ma      = an ? -io.operand_a : io.operand_a;
    mb      = bn ? -io.operand_b : io.operand_b;
    is_div  = op_q >= DIV;
    // acc holds {high product | remainder, low product | quotient}
    add_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, acc_q[0] ? mb_q : {XLEN{1'b0}}};
    trial   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]} - {1'b0, mb_q};
    acc_d   = !is_div ? {add_sum, acc_q[XLEN-1:1]} :
              trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0} :
              {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    prod    = neg_q ? -acc_q : acc_q;
    quo     = dz_q ? {XLEN{1'b1}} : neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_v   = an_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    res_d   = op_q == MUL ? prod[XLEN-1:0] :
              op_q <= MULHU ? prod[2*XLEN-1:XLEN] :
              (op_q == DIV || op_q == DIVU) ? quo : rem_v;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      mb_q     <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      an_q     <= 1'b0;
      dz_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (io.start && !io.flush && is_m) begin
          op_q    <= io.operation;
          mb_q    <= mb;
          acc_q   <= {{XLEN{1'b0}}, ma};
          neg_q   <= an ^ bn;
          an_q    <= an;
          dz_q    <= io.operand_b == '0;
          cnt_q   <= '0;
          busy_q  <= 1'b1;
          state_q <= CALC;
        end
        CALC: if (io.flush) begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end else begin
          acc_q   <= acc_d;
          cnt_q   <= cnt_q + 1'b1;
          state_q <= cnt_q == CW'(XLEN - 1) ? FIX : CALC;
        end
        FIX: begin
          busy_q   <= 1'b0;
          done_q   <= !io.flush;
          result_q <= io.flush ? result_q : res_d;
          state_q  <= io.flush ? IDLE : DONE;
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end
  assign io.busy   = busy_q;
  assign io.done   = done_q;
  assign io.result = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  muldiv_if #(.XLEN(32)) bus();
  muldiv_unit #(.XLEN(32)) dut(.clk(clk), .rst(rst), .io(bus));
  int n_chk = 0;
  int n_pass = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask
  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'b0, a});
    longint ub = longint'({32'b0, b});
    logic [63:0] p;
    logic ovf = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    case (op)
      5'd10: begin p = sa * sb; return p[31:0]; end
      5'd11: begin p = sa * sb; return p[63:32]; end
      5'd12: begin p = sa * ub; return p[63:32]; end
      5'd13: begin p = ua * ub; return p[63:32]; end
      5'd14: return b == 0 ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
      5'd15: return b == 0 ? 32'hFFFF_FFFF : 32'(ua / ub);
      5'd16: return b == 0 ? a : ovf ? 32'h0 : 32'(sa % sb);
      5'd17: return b == 0 ? a : 32'(ua % ub);
      default: return 32'h0;
    endcase
  endfunction
  task automatic count_dones(input int cycles, output int n);
    n = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (bus.done) n++;
    end
  endtask
  task automatic run(input string tag, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input bit hold);
    int lat = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.operation = op;
    bus.operand_a = a;
    bus.operand_b = b;
    do begin
      @(negedge clk);
      lat++;
      bus.start = hold;
      bus.operand_a = $urandom;
      bus.operand_b = $urandom;
      bus.operation = 5'($urandom_range(10, 17));
      if (lat == 1) check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    end while (!bus.done && lat < 60);
    bus.start = 1'b0;
    check({tag, "_lat"}, 32'(lat), 32'd34);
    check(tag, bus.result, exp);
    @(negedge clk);
    check({tag, "_after"}, {30'b0, bus.busy, bus.done}, 32'd0);
  endtask
  initial begin
    int n;
    logic [31:0] prev, a, b;
    logic [4:0] op;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.operation = 5'd0;
    bus.operand_a = '0;
    bus.operand_b = '0;
    rst = 1'b1;
    bus.start = 1'b1;
    bus.operation = 5'd10;
    bus.operand_a = 32'd3;
    bus.operand_b = 32'd4;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b0;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", bus.result, 32'd0);
    bus.start = 1'b1;
    bus.operation = 5'd0;
    @(negedge clk);
    bus.start = 1'b0;
    check("nonm_busy", 32'(bus.busy), 32'd0);
    count_dones(36, n);
    check("nonm_done", 32'(n), 32'd0);
    run("mul", 5'd10, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
    run("mulh", 5'd11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
    run("mulhu", 5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    run("mulhsu", 5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run("div", 5'd14, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
    run("rem", 5'd16, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
    run("divu", 5'd15, 32'd100, 32'd7, 32'd14, 1'b0);
    run("remu", 5'd17, 32'd100, 32'd7, 32'd2, 1'b0);
    run("divu_z", 5'd15, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0);
    run("remu_z", 5'd17, 32'd5, 32'd0, 32'd5, 1'b0);
    run("div_z", 5'd14, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 1'b0);
    run("rem_z", 5'd16, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1'b0);
    run("div_ovf", 5'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    run("rem_ovf", 5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0);
    run("div_hold", 5'd14, 32'd1000, 32'hFFFF_FFF6, 32'hFFFF_FF9C, 1'b1);
    count_dones(40, n);
    check("hold_extra_done", 32'(n), 32'd0);
    prev = bus.result;
    @(negedge clk);
    bus.start = 1'b1;
    bus.operation = 5'd10;
    bus.operand_a = 32'd9;
    bus.operand_b = 32'd9;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_busy", 32'(bus.busy), 32'd0);
    count_dones(40, n);
    check("flush_done", 32'(n), 32'd0);
    check("flush_result", bus.result, prev);
    run("after_flush", 5'd10, 32'd9, 32'd9, 32'd81, 1'b0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.flush = 1'b1;
    bus.operation = 5'd15;
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    check("flush_start_busy", 32'(bus.busy), 32'd0);
    count_dones(40, n);
    check("flush_start_done", 32'(n), 32'd0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.operation = 5'd14;
    bus.operand_a = 32'd50;
    bus.operand_b = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    check("rst_mid_done", 32'(bus.done), 32'd0);
    check("rst_mid_result", bus.result, 32'd0);
    count_dones(40, n);
    check("rst_mid_nodone", 32'(n), 32'd0);
    for (int i = 0; i < 40; i++) begin
      op = 5'($urandom_range(10, 17));
      case ($urandom_range(0, 3))
        0: a = 32'h8000_0000;
        1: a = 32'($urandom_range(0, 200));
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0: b = 32'h0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      run($sformatf("rand%0d_op%0d", i, op), op, a, b, model(op, a, b), 1'($urandom_range(0, 1)));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit, directly downstream of the ALU operation decoder.
- Consumes the decoder's 5-bit operation code for M-extension ops (codes 01010–10001) plus two register operands.
- Produces a single XLEN result after a fixed multi-cycle latency, using a start/busy/done handshake with the execute stage.
- Radix-2 shift-add multiplier and restoring divider share one datapath and state machine.

Parameters:
- XLEN, 32, operand/result width; must be ≥ 8 and even.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- flush  input  1  pipeline kill; aborts any operation in flight
- operation  input  5  decoder op code. MUL=01010, MULH=01011, MULHSU=01100, MULHU=01101, DIV=01110, DIVU=01111, REM=10000, REMU=10001.
- operand_a  input  XLEN  rs1 value (multiplicand/dividend)
- operand_b  input  XLEN  rs2 value (multiplier/divisor)
- busy  output  1  high while an operation is in flight (CALC or FIX)
- done  output  1  one-cycle pulse; result valid
- result  output  XLEN  final value, held until the next accepted start

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, port rst.
- Reset values: busy=0, done=0, result=0, state=IDLE, counter=0, internal registers 0. Reset mid-operation abandons the op with no done pulse.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1 with an M-code on operation: latch op, operands, sign flags and |a|, |b| (signedness per op); counter=0; go to CALC.
  - start=1 with any other code is ignored: stays IDLE, no done.
  - start=0: stays IDLE.
- CALC: one iteration per cycle for exactly XLEN cycles, then FIX.
  - Multiply: 2·XLEN-bit accumulator, shift-add of unsigned magnitudes.
  - Divide: restoring shift-subtract, quotient/remainder of magnitudes.
- FIX: apply sign correction and select the result, then go to DONE.
  - MUL: low XLEN bits.
  - MULH/MULHSU/MULHU: high XLEN bits. Product is negated if operand signs differ; MULHSU treats b as unsigned.
  - DIV/REM: quotient negated if signs differ; remainder takes the dividend's sign.
  - Divide by zero: quotient = all ones; remainder = operand_a (unmodified, both signed and unsigned).
  - Signed overflow (a=most-negative, b=−1, DIV/REM only): quotient = a, remainder = 0.
  - Special cases still take the full latency; latency is fixed for all ops.
- DONE: done=1 for exactly this cycle, then IDLE. result updates on entry to DONE and is stable thereafter.
- Latency: start accepted at edge k → busy=1 from cycle k+1 through k+XLEN+1 → done=1 in cycle k+XLEN+2. That is 34 cycles for XLEN=32.
- start while busy or in DONE is ignored. No queuing; the issuer must wait for done.
- flush:
  - Overrides everything: next state IDLE, busy=0, no done pulse, result keeps its prior value.
  - flush with start in the same IDLE cycle: start is dropped.
  - flush in the DONE cycle: done still asserts that cycle (already committed), state → IDLE.
- rst has priority over flush; flush has priority over start.
- Operands and operation are don't-care after the accepting edge; changing them mid-operation has no effect.

Test Plan:
- Reset then idle: rst=1 for 2 cycles with start=1 → busy=0, done=0, result=0. Non-M op (00000) with start → no busy, no done.
- MUL a=7, b=0xFFFFFFFD → done exactly 34 cycles after start, result=0xFFFFFFEB. Back-to-back MULH a=b=0x80000000 → 0x40000000. MULHU a=b=0xFFFFFFFF → 0xFFFFFFFE. MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF → 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (−7), b=2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- Divide by zero: DIVU a=5, b=0 → 0xFFFFFFFF; REMU → 5; DIV a=0xFFFFFFF9, b=0 → 0xFFFFFFFF; REM → 0xFFFFFFF9. Overflow: DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
- Handshake: start re-asserted every cycle during a DIV → only one done; result matches the first operands. Operands changed after the accept edge → result unaffected.
- Flush and reset: flush at cycle 10 of a MUL → busy drops next cycle, no done, result retains previous value; a new start next cycle completes normally. rst mid-CALC → outputs return to reset values.
